// File: rtl/serial_fa_sequencer.sv
// serial_fa_sequencer: drives one external 1-bit full-adder cell across a
// WIDTH-bit operand pair, LSB first, holding the carry in a flop between
// slices. Operands are captured on an accepted start. The assembled sum and
// carry-out are loaded on the completing edge, and done pulses for one cycle.
// Optional feature macro: SERIAL_FA_SUB_EN adds a 'sub' input that selects
// A-B (two's complement; cout=1 means no borrow).
module serial_fa_sequencer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef SERIAL_FA_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_sum,
   input  logic             fa_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic              carry_q, carry_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  r_q, r_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              cout_q, cout_d;
   logic [WIDTH-1:0]  r_shift;

   // Result shift built with shifts rather than a part-select so WIDTH=1 stays legal
   assign r_shift = (r_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

   // Cell drive is live only while slicing; zero in IDLE and DONE
   assign fa_a   = (state_q == RUN) ? a_q[0]  : 1'b0;
   assign fa_b   = (state_q == RUN) ? b_q[0]  : 1'b0;
   assign fa_cin = (state_q == RUN) ? carry_q : 1'b0;
   assign busy   = (state_q == RUN);
   assign done   = (state_q == DONE);
   assign sum    = sum_q;
   assign cout   = cout_q;

   // Next-state and datapath: capture on start, one bit slice per RUN cycle
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = a_in;
`ifdef SERIAL_FA_SUB_EN
               b_d     = sub ? ~b_in : b_in;
               carry_d = sub ? 1'b1 : cin;
`else
               b_d     = b_in;
               carry_d = cin;
`endif
               cnt_d   = '0;
               r_d     = '0;
               state_d = RUN;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            r_d     = r_shift;
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = fa_cout;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               sum_d   = r_shift;
               cout_d  = fa_cout;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         r_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

endmodule

// File: tb/tb_serial_fa_sequencer.sv
// Bench for serial_fa_sequencer: WIDTH=8 instance with a scoreboard of expected
// {cout,sum} values, plus a WIDTH=1 instance. The full-adder cell is modelled here.
module tb_serial_fa_sequencer;
   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic         start, cin, fa_a, fa_b, fa_cin, fa_sum, fa_cout, busy, done, cout;
   logic [W-1:0] a_in, b_in, sum;
`ifdef SERIAL_FA_SUB_EN
   logic         sub, sub1;
`endif

   logic start1, a1, b1, cin1, fa_a1, fa_b1, fa_cin1, fa_sum1, fa_cout1;
   logic busy1, done1, sum1, cout1;

   assign fa_sum   = fa_a ^ fa_b ^ fa_cin;
   assign fa_cout  = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
   assign fa_sum1  = fa_a1 ^ fa_b1 ^ fa_cin1;
   assign fa_cout1 = (fa_a1 & fa_b1) | (fa_a1 & fa_cin1) | (fa_b1 & fa_cin1);

   serial_fa_sequencer #(.WIDTH(W)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start),
`ifdef SERIAL_FA_SUB_EN
      .sub(sub),
`endif
      .a_in(a_in), .b_in(b_in), .cin(cin),
      .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
      .fa_sum(fa_sum), .fa_cout(fa_cout),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   serial_fa_sequencer #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
`ifdef SERIAL_FA_SUB_EN
      .sub(sub1),
`endif
      .a_in(a1), .b_in(b1), .cin(cin1),
      .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1),
      .fa_sum(fa_sum1), .fa_cout(fa_cout1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [W:0] exp_q[$];

   // Drive a one-cycle start at a negedge and record the expected result
   task automatic push_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      logic [W:0] e;
      logic [W:0] cc;
      cc    = '0;
      cc[0] = c;
      e     = {1'b0, a} + {1'b0, b} + cc;
      exp_q.push_back(e);
      start = 1'b1; a_in = a; b_in = b; cin = c;
      @(negedge clk);
      start = 1'b0;
   endtask

`ifdef SERIAL_FA_SUB_EN
   task automatic push_sub(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] e;
      logic [W-1:0] nb;
      nb = ~b;
      e  = {1'b0, a} + {1'b0, nb} + 9'd1;
      exp_q.push_back(e);
      start = 1'b1; sub = 1'b1; a_in = a; b_in = b; cin = 1'b0;
      @(negedge clk);
      start = 1'b0; sub = 1'b0;
   endtask
`endif

   // Advance negedges until done, counting the cycles waited (bounded)
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 64) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
      start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
`ifdef SERIAL_FA_SUB_EN
      sub = 1'b0; sub1 = 1'b0;
`endif
      #2;
      n_checks++;
      if ({busy, done, sum, cout, fa_a, fa_b, fa_cin} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b fa=%b%b%b, want all 0",
                  busy, done, sum, cout, fa_a, fa_b, fa_cin);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_latency();
      int cyc;
      logic [W:0] e;
      logic held;
      push_start(8'h35, 8'h4A, 1'b0);
      held = 1'b1;
      cyc  = 0;
      while (busy && cyc < 40) begin
         if (sum !== 8'h00 || cout !== 1'b0) held = 1'b0;
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if (cyc != 8 || done !== 1'b1) begin
         n_fail++;
         $display("FAIL latency: got busy_cycles=%0d done=%b, want 8 and 1", cyc, done);
      end
      n_checks++;
      if (!held) begin
         n_fail++;
         $display("FAIL hold_while_busy: sum/cout changed during RUN, want stable 00/0");
      end
      e = exp_q.pop_front();
      n_checks++;
      if ({cout, sum} !== e) begin
         n_fail++;
         $display("FAIL add_35_4a: got cout=%b sum=%h, want cout=%b sum=%h", cout, sum, e[W], e[W-1:0]);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h7F) begin
         n_fail++;
         $display("FAIL done_pulse_idle: got done=%b busy=%b sum=%h, want 0 0 7f", done, busy, sum);
      end
   endtask

   task automatic test_carry_chain();
      logic [W-1:0] tr_a, tr_b, tr_c;
      logic [W:0] e;
      push_start(8'hFF, 8'h01, 1'b0);
      for (int i = 0; i < 8; i++) begin
         tr_a[i] = fa_a; tr_b[i] = fa_b; tr_c[i] = fa_cin;
         @(negedge clk);
      end
      n_checks++;
      if (tr_c !== 8'hFE || tr_a !== 8'hFF || tr_b !== 8'h01) begin
         n_fail++;
         $display("FAIL fa_drive_trace: got a=%h b=%h cin=%h, want ff 01 fe", tr_a, tr_b, tr_c);
      end
      n_checks++;
      if (done !== 1'b1 || fa_cin !== 1'b0 || fa_a !== 1'b0) begin
         n_fail++;
         $display("FAIL done_drive_zero: got done=%b fa_a=%b fa_cin=%b, want 1 0 0", done, fa_a, fa_cin);
      end
      e = exp_q.pop_front();
      n_checks++;
      if ({cout, sum} !== e) begin
         n_fail++;
         $display("FAIL add_ff_01: got cout=%b sum=%h, want cout=%b sum=%h", cout, sum, e[W], e[W-1:0]);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int cyc;
      logic [W:0] e;
      push_start(8'hFF, 8'hFF, 1'b1);
      wait_done(cyc);
      e = exp_q.pop_front();
      n_checks++;
      if (done !== 1'b1 || {cout, sum} !== e) begin
         n_fail++;
         $display("FAIL add_ff_ff_1: got done=%b cout=%b sum=%h, want 1 %b %h", done, cout, sum, e[W], e[W-1:0]);
      end
      push_start(8'h01, 8'h01, 1'b0);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_no_idle: got busy=%b after start in DONE, want 1", busy);
      end
      wait_done(cyc);
      e = exp_q.pop_front();
      n_checks++;
      if (cyc != 8 || {cout, sum} !== e) begin
         n_fail++;
         $display("FAIL add_01_01: got cyc=%0d cout=%b sum=%h, want 8 %b %h", cyc, cout, sum, e[W], e[W-1:0]);
      end
      for (int k = 0; k < 6; k++) begin
         push_start(W'($urandom), W'($urandom), 1'($urandom));
         wait_done(cyc);
         e = exp_q.pop_front();
         n_checks++;
         if (cyc != 8 || {cout, sum} !== e) begin
            n_fail++;
            $display("FAIL random_%0d: got cyc=%0d cout=%b sum=%h, want 8 %b %h", k, cyc, cout, sum, e[W], e[W-1:0]);
         end
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_start_while_busy();
      int cyc, ndone;
      logic [W:0] e;
      exp_q.push_back(9'h07F);
      start = 1'b1; a_in = 8'h35; b_in = 8'h4A; cin = 1'b0;
      @(negedge clk);
      cyc = 0;
      while (!done && cyc < 40) begin
         if (cyc == 3) begin a_in = 8'h00; b_in = 8'hFF; cin = 1'b1; end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (cyc != 8 || done !== 1'b1 || {cout, sum} !== e) begin
         n_fail++;
         $display("FAIL busy_ignore: got cyc=%0d done=%b cout=%b sum=%h, want 8 1 %b %h",
                  cyc, done, cout, sum, e[W], e[W-1:0]);
      end
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      n_checks++;
      if (ndone != 0) begin
         n_fail++;
         $display("FAIL single_done: got %0d extra done pulses, want 0", ndone);
      end
   endtask

   task automatic test_reset_mid_run();
      int cyc;
      logic [W:0] e;
      logic saw_done;
      push_start(8'h0F, 8'h01, 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      void'(exp_q.pop_front());
      n_checks++;
      if ({busy, done, sum, cout, fa_a, fa_b, fa_cin} !== '0) begin
         n_fail++;
         $display("FAIL reset_abort: got busy=%b done=%b sum=%h cout=%b fa=%b%b%b, want all 0",
                  busy, done, sum, cout, fa_a, fa_b, fa_cin);
      end
      saw_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
         if (i == 1) rst_n = 1'b1;
      end
      n_checks++;
      if (saw_done) begin
         n_fail++;
         $display("FAIL reset_no_done: got a done pulse after abort, want none");
      end
      push_start(8'h0F, 8'h01, 1'b0);
      wait_done(cyc);
      e = exp_q.pop_front();
      n_checks++;
      if (cyc != 8 || {cout, sum} !== e) begin
         n_fail++;
         $display("FAIL after_reset_0f_01: got cyc=%0d cout=%b sum=%h, want 8 %b %h", cyc, cout, sum, e[W], e[W-1:0]);
      end
      @(negedge clk);
   endtask

   task automatic test_width1();
      start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n_checks++;
      if (busy1 !== 1'b1 || fa_cin1 !== 1'b1) begin
         n_fail++;
         $display("FAIL w1_run: got busy=%b fa_cin=%b, want 1 1", busy1, fa_cin1);
      end
      @(negedge clk);
      n_checks++;
      if (done1 !== 1'b1 || sum1 !== 1'b1 || cout1 !== 1'b1) begin
         n_fail++;
         $display("FAIL w1_111: got done=%b sum=%b cout=%b, want 1 1 1", done1, sum1, cout1);
      end
      start1 = 1'b1; a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
      @(negedge clk);
      start1 = 1'b0;
      @(negedge clk);
      n_checks++;
      if (done1 !== 1'b1 || sum1 !== 1'b1 || cout1 !== 1'b0) begin
         n_fail++;
         $display("FAIL w1_100: got done=%b sum=%b cout=%b, want 1 1 0", done1, sum1, cout1);
      end
      @(negedge clk);
   endtask

`ifdef SERIAL_FA_SUB_EN
   task automatic test_subtract();
      int cyc;
      logic [W:0] e;
      push_sub(8'h10, 8'h01);
      wait_done(cyc);
      e = exp_q.pop_front();
      n_checks++;
      if ({cout, sum} !== e || e !== 9'h10F) begin
         n_fail++;
         $display("FAIL sub_10_01: got cout=%b sum=%h, want cout=1 sum=0f", cout, sum);
      end
      push_sub(8'h01, 8'h02);
      wait_done(cyc);
      e = exp_q.pop_front();
      n_checks++;
      if ({cout, sum} !== e || e !== 9'h0FF) begin
         n_fail++;
         $display("FAIL sub_01_02: got cout=%b sum=%h, want cout=0 sum=ff", cout, sum);
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_latency();
      test_carry_chain();
      test_back_to_back();
      test_start_while_busy();
      test_reset_mid_run();
      test_width1();
`ifdef SERIAL_FA_SUB_EN
      test_subtract();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
